// File: rtl/sfx_state_ctrl.sv
// sfx_state_ctrl: turns game event pulses into held L/R channel states
// for the beat sequencers, with prioritised and beat-timed R clips.
module sfx_state_ctrl #(
    parameter int SFX_BEATS = 256,
    parameter int CW        = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       beat_tick,
    input  logic       coin_deposited,
    input  logic       game_over,
    input  logic       good_ball,
    input  logic       bad_ball,
    input  logic       high_score,
    output logic       state_for_L_ch,
    output logic [1:0] state_for_R_ch,
    output logic       sfx_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [CW-1:0] BEATS_W = CW'(SFX_BEATS);

    state_t        state_q, state_d;
    logic          l_q, l_d;
    logic [1:0]    r_q, r_d;
    logic [1:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [1:0]    req_k;
    logic          req_v;
    logic [CW-1:0] cnt_inc;

    // Collapse simultaneous requests to the highest-priority kind
    always_comb begin
        req_k = 2'b00;
        if (high_score) begin
            req_k = 2'b11;
        end else if (bad_ball) begin
            req_k = 2'b10;
        end else if (good_ball) begin
            req_k = 2'b01;
        end
    end

    assign req_v   = |req_k;
    assign cnt_inc = cnt_q + CW'(1);

    // Next-state logic for the L channel and the R clip FSM
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        // game_over wins over a coincident coin
        if (game_over) begin
            l_d = 1'b0;
        end else if (coin_deposited) begin
            l_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // a tick in the entry cycle is not counted
                if (req_v) begin
                    state_d = PLAY;
                    r_d     = req_k;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            PLAY: begin
                if (req_v && (req_k > r_q)) begin
                    r_d   = req_k;
                    cnt_d = '0;
                end else if (req_v && (req_k == r_q)) begin
                    // drop to silence so the sequencer sees a fresh start
                    state_d = GAP;
                    r_d     = 2'b00;
                    pend_d  = req_k;
                end else if (beat_tick) begin
                    if (cnt_inc == BEATS_W) begin
                        state_d = IDLE;
                        r_d     = 2'b00;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            GAP: begin
                if (req_v && (req_k > pend_q)) begin
                    pend_d = req_k;
                end
                if (beat_tick) begin
                    state_d = PLAY;
                    r_d     = pend_d;
                    pend_d  = 2'b00;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                r_d     = 2'b00;
                pend_d  = 2'b00;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            l_q     <= 1'b0;
            r_q     <= 2'b00;
            pend_q  <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign state_for_L_ch = l_q;
    assign state_for_R_ch = r_q;
    assign sfx_busy       = busy_q;

endmodule

// File: tb/tb_sfx_state_ctrl.sv
// tb_sfx_state_ctrl: directed vector table plus a timed clip sequence
// for sfx_state_ctrl with a 4-beat clip.
module tb_sfx_state_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       beat_tick;
    logic       coin_deposited;
    logic       game_over;
    logic       good_ball;
    logic       bad_ball;
    logic       high_score;
    logic       state_for_L_ch;
    logic [1:0] state_for_R_ch;
    logic       sfx_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       coin;
        logic       go;
        logic       gb;
        logic       bb;
        logic       hs;
        logic       l;
        logic [1:0] r;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    sfx_state_ctrl #(
        .SFX_BEATS(4),
        .CW(9)
    ) dut (
        .clk(clk),
        .reset(reset),
        .beat_tick(beat_tick),
        .coin_deposited(coin_deposited),
        .game_over(game_over),
        .good_ball(good_ball),
        .bad_ball(bad_ball),
        .high_score(high_score),
        .state_for_L_ch(state_for_L_ch),
        .state_for_R_ch(state_for_R_ch),
        .sfx_busy(sfx_busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        reset          = v.rst;
        beat_tick      = v.tick;
        coin_deposited = v.coin;
        game_over      = v.go;
        good_ball      = v.gb;
        bad_ball       = v.bb;
        high_score     = v.hs;
    endtask

    task automatic check(input string name, input logic l,
                         input logic [1:0] r, input logic b);
        checks++;
        if ({state_for_L_ch, state_for_R_ch, sfx_busy} !== {l, r, b}) begin
            errors++;
            $display("FAIL %s: got L=%b R=%b busy=%b, want L=%b R=%b busy=%b",
                     name, state_for_L_ch, state_for_R_ch, sfx_busy, l, r, b);
        end
    endtask

    task automatic add(input logic rst, input logic tick, input logic coin,
                       input logic go, input logic gb, input logic bb,
                       input logic hs, input logic l, input logic [1:0] r,
                       input logic busy);
        vec_t v;
        v = '{rst, tick, coin, go, gb, bb, hs, l, r, busy};
        vecs.push_back(v);
    endtask

    initial begin
        vec_t idle_v;
        int   ticks;
        idle_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 2'b00, 1'b0};
        drive(idle_v);

        //  rst tk cn go gb bb hs   L  R      busy
        add(1, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0); // 0 reset
        add(1, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0);
        add(0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0);
        add(0, 0, 1, 0, 0, 0, 0,   1, 2'b00, 0); // 4 coin
        add(0, 0, 0, 0, 0, 0, 0,   1, 2'b00, 0);
        add(0, 0, 1, 1, 0, 0, 0,   0, 2'b00, 0); // 6 go wins
        add(0, 0, 1, 0, 0, 0, 0,   1, 2'b00, 0);
        add(0, 0, 0, 1, 0, 0, 0,   0, 2'b00, 0);
        add(0, 0, 0, 0, 1, 0, 0,   0, 2'b01, 1); // 9 good
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1); // cnt1
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1); // cnt2
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1); // cnt3
        add(0, 0, 0, 0, 0, 0, 0,   0, 2'b01, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b00, 0); // 14 expire
        add(0, 1, 0, 0, 1, 1, 1,   0, 2'b11, 1); // 15 all req + tick
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b11, 1); // cnt1
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b11, 1); // cnt2
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b11, 1); // cnt3
        add(0, 1, 0, 0, 0, 0, 1,   0, 2'b00, 1); // 19 retrig on expiry
        add(0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b11, 1); // 21 gap ends
        add(0, 0, 0, 0, 1, 0, 0,   0, 2'b11, 1); // lower dropped
        add(1, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0); // 23 reset mid clip
        add(0, 1, 0, 0, 1, 0, 0,   0, 2'b01, 1); // 24 entry tick
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1); // cnt1
        add(0, 1, 0, 0, 0, 1, 0,   0, 2'b10, 1); // 26 preempt
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b10, 1); // cnt1
        add(0, 0, 0, 0, 1, 0, 0,   0, 2'b10, 1); // lower dropped
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b10, 1); // cnt2
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b10, 1); // cnt3
        add(0, 0, 0, 0, 0, 1, 0,   0, 2'b00, 1); // 31 retrigger
        add(0, 0, 0, 0, 0, 0, 0,   0, 2'b00, 1);
        add(0, 0, 0, 0, 0, 0, 1,   0, 2'b00, 1); // pend -> 11
        add(0, 0, 0, 0, 0, 1, 0,   0, 2'b00, 1); // dropped
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b11, 1); // 35 plays 11
        add(0, 0, 0, 0, 0, 0, 1,   0, 2'b00, 1); // gap pend 11
        add(1, 0, 0, 0, 0, 0, 0,   0, 2'b00, 0); // 37 reset mid gap
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b00, 0); // no clip
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b00, 0);
        add(0, 0, 1, 0, 1, 0, 0,   1, 2'b01, 1); // 40 L and R
        add(0, 0, 0, 1, 0, 0, 0,   0, 2'b01, 1);
        add(0, 1, 0, 0, 1, 0, 0,   0, 2'b00, 1); // 42 gap + tick
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1); // 43 restart
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b01, 1);
        add(0, 1, 0, 0, 0, 0, 0,   0, 2'b00, 0); // 47 expire

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].busy);
        end

        // reset, then 10 idle cycles
        @(negedge clk);
        drive(idle_v);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle10", 1'b0, 2'b00, 1'b0);

        // good_ball in cycle 0, beat_tick every 8 cycles
        ticks = 0;
        good_ball = 1'b1;
        @(posedge clk);
        #1;
        check("clip_start", 1'b0, 2'b01, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            drive(idle_v);
            beat_tick = (c % 8 == 0);
            @(posedge clk);
            #1;
            if (beat_tick) ticks++;
            if (ticks < 4) begin
                check($sformatf("clip_c%0d", c), 1'b0, 2'b01, 1'b1);
            end else begin
                check($sformatf("clip_c%0d", c), 1'b0, 2'b00, 1'b0);
            end
        end
        @(negedge clk);
        drive(idle_v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
